// File: rtl/gaussian_blur_if.sv
// Bus bundle for gaussian_blur: pass control, source-BRAM read port and destination-BRAM write port.
// The master modport is the blur engine; the slave modport is its surroundings (BRAMs and controller).
interface gaussian_blur_if #(
    parameter int ADDR_W = 12
) ();
    logic              start;
    logic [ADDR_W-1:0] read_addr;
    logic [7:0]        pixel_in;
    logic [ADDR_W-1:0] write_addr;
    logic              write_valid;
    logic [7:0]        pixel_out;
    logic              busy;
    logic              done;
    logic [1:0]        state_num;

    modport master (
        input  start, pixel_in,
        output read_addr, write_addr, write_valid, pixel_out, busy, done, state_num
    );

    modport slave (
        output start, pixel_in,
        input  read_addr, write_addr, write_valid, pixel_out, busy, done, state_num
    );
endinterface

// File: rtl/gaussian_blur.sv
// 3x3 binomial Gaussian blur over a DIMENSION x DIMENSION 8-bit image held in a source BRAM.
// Each tap is fetched one at a time. Edge pixels are clamped. Results go to a destination BRAM.
module gaussian_blur #(
    parameter int DIMENSION    = 64,
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_W       = $clog2(DIMENSION * DIMENSION)
) (
    input  logic          clk,
    input  logic          rst_in,
    gaussian_blur_if.master bus
);
    localparam int RC_W   = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam int WAIT_W = $clog2(BRAM_LATENCY + 1);
    localparam int ACC_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
    logic [3:0]        tap_q, tap_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [7:0]        pixel_out_q, pixel_out_d;
    logic [2:0]        tap_weight [9];
    logic              last_pixel;

    // Kernel [1 2 1; 2 4 2; 1 2 1] in row-major tap order.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_weight
            assign tap_weight[gi] = (gi == 4) ? 3'd4 : (((gi % 2) == 1) ? 3'd2 : 3'd1);
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] tap_addr(input int r, input int c, input int tap);
        int rr;
        int cc;
        rr = r + tap / 3 - 1;
        cc = c + tap % 3 - 1;
        if (rr < 0) rr = 0;
        else if (rr > DIMENSION - 1) rr = DIMENSION - 1;
        if (cc < 0) cc = 0;
        else if (cc > DIMENSION - 1) cc = DIMENSION - 1;
        return ADDR_W'(rr * DIMENSION + cc);
    endfunction

    assign acc_sum    = acc_q + ACC_W'(bus.pixel_in) * ACC_W'(tap_weight[tap_q]);
    assign last_pixel = (row_q == RC_W'(DIMENSION - 1)) && (col_q == RC_W'(DIMENSION - 1));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        tap_d        = tap_q;
        wait_d       = wait_q;
        acc_d        = acc_q;
        read_addr_d  = read_addr_q;
        write_addr_d = write_addr_q;
        pixel_out_d  = pixel_out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = FETCH;
                    row_d       = '0;
                    col_d       = '0;
                    tap_d       = '0;
                    wait_d      = '0;
                    acc_d       = '0;
                    read_addr_d = tap_addr(0, 0, 0);
                end
            end
            FETCH: begin
                if (wait_q == WAIT_W'(BRAM_LATENCY)) begin
                    acc_d  = acc_sum;
                    wait_d = '0;
                    if (tap_q == 4'd8) begin
                        state_d      = WRITE;
                        tap_d        = '0;
                        write_addr_d = tap_addr(int'(row_q), int'(col_q), 4);
                        // Max sum 4080 + 8 still fits 12 bits, so no carry is lost.
                        pixel_out_d  = 8'((acc_sum + ACC_W'(8)) >> 4);
                    end else begin
                        tap_d       = tap_q + 4'd1;
                        read_addr_d = tap_addr(int'(row_q), int'(col_q), int'(tap_q) + 1);
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WRITE: begin
                acc_d = '0;
                if (last_pixel) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                    if (col_q == RC_W'(DIMENSION - 1)) begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                    read_addr_d = tap_addr(int'(row_d), int'(col_d), 0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            tap_q        <= '0;
            wait_q       <= '0;
            acc_q        <= '0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            pixel_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            tap_q        <= tap_d;
            wait_q       <= wait_d;
            acc_q        <= acc_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            pixel_out_q  <= pixel_out_d;
        end
    end

    assign bus.read_addr   = read_addr_q;
    assign bus.write_addr  = write_addr_q;
    assign bus.pixel_out   = pixel_out_q;
    assign bus.write_valid = (state_q == WRITE);
    assign bus.busy        = (state_q == FETCH) || (state_q == WRITE);
    assign bus.done        = (state_q == DONE);
    assign bus.state_num   = state_q;
endmodule

// File: tb/tb_gaussian_blur.sv
// Self-checking bench for gaussian_blur (D=4, L=2): table vectors, random images against a
// reference blur, plus pass timing, mid-pass start and mid-pass reset sequences.
module tb_gaussian_blur;
    localparam int D  = 4;
    localparam int L  = 2;
    localparam int N  = D * D;
    localparam int AW = $clog2(N);
    localparam int PIX_CYC = 9 * (L + 1) + 1;

    typedef struct {
        int img;
        int idx;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_in;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    gaussian_blur_if #(.ADDR_W(AW)) bus ();

    gaussian_blur #(.DIMENSION(D), .BRAM_LATENCY(L), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source BRAM with two-cycle registered read.
    logic [7:0] src [N];
    logic [7:0] dst [N];
    logic [7:0] rd_pipe;
    always @(posedge clk) begin
        rd_pipe      <= src[bus.read_addr];
        bus.pixel_in <= rd_pipe;
    end

    int wr_addr [$];
    int wr_data [$];
    int wr_cyc  [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_at_done = 0;

    always @(negedge clk) begin
        if (bus.write_valid) begin
            wr_addr.push_back(int'(bus.write_addr));
            wr_data.push_back(int'(bus.pixel_out));
            wr_cyc.push_back(cyc);
            dst[bus.write_addr] = bus.pixel_out;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(bus.busy);
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > D - 1) ? D - 1 : v);
    endfunction

    // Direct convolution over the image with clamped neighbours.
    function automatic int blur_ref(input int r, input int c);
        int sum;
        int w;
        sum = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                w = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
                sum += w * int'(src[clamp(r + dr) * D + clamp(c + dc)]);
            end
        end
        return (sum + 8) / 16;
    endfunction

    task automatic load_image(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       src[i] = 8'd100;
                1:       src[i] = (i == 1 * D + 1) ? 8'd255 : 8'd0;
                2:       src[i] = (i == 0) ? 8'd160 : 8'd0;
                3:       src[i] = 8'd255;
                default: src[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Called at #1 after a posedge; raises start in the current cycle t0.
    task automatic run_pass(input int repulse_at, output int t0);
        bit seen;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        for (int i = 0; i < N; i++) dst[i] = 8'd0;
        t0 = cyc;
        bus.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clk);
            #1;
            bus.start = (repulse_at > 0 && cyc == t0 + repulse_at) ? 1'b1 : 1'b0;
            if (i == 0) begin
                check("busy_after_start", int'(bus.busy), 1);
                check("first_read_addr", int'(bus.read_addr), 0);
            end
            if (done_cnt > 0) seen = 1'b1;
        end
        bus.start = 1'b0;
        check("done_seen", int'(seen), 1);
    endtask

    task automatic check_pass(input int t0);
        check("done_count", done_cnt, 1);
        check("done_one_cycle", int'(bus.done), 0);
        check("done_cycle", done_cyc - t0, N * PIX_CYC + 1);
        check("busy_at_done", busy_at_done, 0);
        check("write_count", wr_addr.size(), N);
        if (wr_cyc.size() > 0) begin
            check("first_write_cycle", wr_cyc[0] - t0, PIX_CYC);
            check("last_write_cycle", wr_cyc[wr_cyc.size() - 1] - t0, N * PIX_CYC);
        end
        foreach (wr_addr[i]) begin
            check("write_addr_order", wr_addr[i], i);
            check("pixel_vs_model", wr_data[i], blur_ref(wr_addr[i] / D, wr_addr[i] % D));
        end
        $display("pass t0=%0d writes=%0d done_at=+%0d", t0, wr_addr.size(), done_cyc - t0);
    endtask

    initial begin
        vec_t vt [22];
        int   loaded;
        int   t0;

        vt[0]  = '{0, 0, 100};  vt[1]  = '{0, 5, 100};  vt[2]  = '{0, 15, 100};
        vt[3]  = '{1, 5, 64};   vt[4]  = '{1, 1, 32};   vt[5]  = '{1, 4, 32};
        vt[6]  = '{1, 6, 32};   vt[7]  = '{1, 9, 32};   vt[8]  = '{1, 0, 16};
        vt[9]  = '{1, 2, 16};   vt[10] = '{1, 8, 16};   vt[11] = '{1, 10, 16};
        vt[12] = '{1, 3, 0};    vt[13] = '{1, 15, 0};   vt[14] = '{2, 0, 90};
        vt[15] = '{2, 1, 30};   vt[16] = '{2, 4, 30};   vt[17] = '{2, 5, 10};
        vt[18] = '{2, 2, 0};    vt[19] = '{3, 0, 255};  vt[20] = '{3, 10, 255};
        vt[21] = '{3, 15, 255};

        rst_in = 1'b1;
        bus.start = 1'b0;
        load_image(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_write_valid", int'(bus.write_valid), 0);
        check("rst_pixel_out", int'(bus.pixel_out), 0);
        check("rst_write_addr", int'(bus.write_addr), 0);
        check("rst_read_addr", int'(bus.read_addr), 0);
        check("rst_state_num", int'(bus.state_num), 0);

        // start coinciding with reset must be dropped
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_state", int'(bus.state_num), 0);
        check("rst_start_busy", int'(bus.busy), 0);

        // Table vectors; consecutive passes start the cycle after done.
        loaded = -1;
        for (int i = 0; i < 22; i++) begin
            if (vt[i].img != loaded) begin
                load_image(vt[i].img);
                run_pass(0, t0);
                check_pass(t0);
                loaded = vt[i].img;
            end
            $display("vec %0d img %0d idx %0d pixel_out %0d expected %0d",
                     i, vt[i].img, vt[i].idx, dst[vt[i].idx], vt[i].exp);
            check("table_pixel", int'(dst[vt[i].idx]), vt[i].exp);
        end

        for (int k = 0; k < 3; k++) begin
            load_image(4);
            run_pass(0, t0);
            check_pass(t0);
        end

        // start re-pulsed mid-pass must not disturb the pass
        load_image(4);
        run_pass(100, t0);
        check_pass(t0);

        // reset mid-pass
        load_image(4);
        done_cnt = 0;
        t0 = cyc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_state", int'(bus.state_num), 0);
        check("midrst_write_valid", int'(bus.write_valid), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_write_addr", int'(bus.write_addr), 0);
        $display("mid-pass reset at +%0d", cyc - t0 - 1);
        repeat (500) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", int'(bus.state_num), 0);
        run_pass(0, t0);
        check_pass(t0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gaussian_blur.md
# gaussian_blur

Upstream neighbour of the `dog` stage: reads an 8-bit greyscale DIMENSION×DIMENSION image from a source BRAM, applies a 3×3 binomial Gaussian kernel with edge clamping, and writes the blurred image to a destination BRAM. Each `dog` pair (sharper/fuzzier) comes from two cascaded passes of this block. On finishing a pass it pulses `done`, which the top level forwards as `bram_ready` to `dog`.

## Interface
- DIMENSION, 64, image side length in pixels (image is DIMENSION×DIMENSION, row-major).
- BRAM_LATENCY, 2, source BRAM read latency in cycles (≥1).
- ADDR_W, $clog2(DIMENSION*DIMENSION), address width.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_in  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse begins a pass; ignored while busy.
- read_addr  out  ADDR_W  source BRAM read address.
- pixel_in  in  8  source BRAM read data, valid BRAM_LATENCY cycles after read_addr.
- write_addr  out  ADDR_W  destination BRAM write address.
- write_valid  out  1  destination write enable, one cycle per output pixel.
- pixel_out  out  8  blurred pixel, valid when write_valid.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  one-cycle pulse after final write.
- state_num  out  2  current FSM state encoding, for debug.

## Operation
- Kernel weights [1 2 1; 2 4 2; 1 2 1], sum 16.
- Output pixel (r,c) = (Σ w·p + 8) >> 4. Accumulator is 12 bits (max 4080). Result is max 255, so no saturation is needed.
- Neighbour coordinates are clamped to [0, DIMENSION-1] per axis. Clamped taps re-read the edge pixel.
- Address = row·DIMENSION + col.
- Output pixels are produced in row-major order, (0,0) first.
- Taps are visited in row-major order from (-1,-1) to (+1,+1).
- FSM states (state_num):
  - IDLE=0: on start, go to FETCH. Clear the accumulator and set r=c=tap=0.
  - FETCH=1: drive read_addr for the current tap, then wait BRAM_LATENCY cycles. On the last wait cycle, add weight·pixel_in to the accumulator. Then advance the tap. After tap 8, go to WRITE.
  - WRITE=2: assert write_valid for one cycle, with write_addr=r·D+c and rounded pixel_out. Then clear the accumulator. If the pixel was (D-1,D-1), go to DONE; otherwise advance c (wrapping into r) and return to FETCH.
  - DONE=3: pulse done for one cycle, deassert busy, return to IDLE.
- start while busy: ignored, with no effect on the current pass.
- read_addr holds its last value outside FETCH. Its content is don't-care, but it must be a valid in-range address.

## Timing
- Reset values: state IDLE, busy=0, done=0, write_valid=0, pixel_out=0, write_addr=0, read_addr=0, state_num=0.
- start sampled high in IDLE at cycle t: busy=1 and the first read_addr is presented at t+1.
- Each tap takes BRAM_LATENCY+1 cycles. Each output pixel takes 9·(BRAM_LATENCY+1)+1 cycles.
- Full pass: D²·(9(L+1)+1) cycles from the first FETCH cycle to the last write_valid. done follows the last write by 1 cycle. busy falls in the same cycle that done rises.
- Back-to-back start pulses: a start on the cycle after done (state IDLE) is accepted.
- rst_in mid-pass: next cycle is IDLE with all outputs at reset values. No done pulse. A partial destination image is permitted.
- rst_in and start in the same cycle: reset wins and start is dropped.

## Test plan
- Uniform source, all pixels = 100, D=4, L=2 -> 16 writes, every pixel_out=100, write_addr 0..15 in order.
- Impulse 255 at (1,1), others 0, D=4 -> pixel_out(1,1)=64; (0,1),(1,0),(1,2),(2,1)=32; diagonals (0,0),(0,2),(2,0),(2,2)=16; all other pixels 0.
- Corner clamp: 160 at (0,0), others 0 -> pixel_out(0,0)=90 (weight 9), (0,1)=30 (weight 3), (1,1)=10.
- Cycle count, D=4, L=2: start at t -> first write_valid at t+28, last at t+448, done=1 at t+449 for exactly one cycle, busy low from t+449.
- start re-pulsed at t+100 mid-pass -> ignored: write count stays 16, timing unchanged.
- rst_in at t+200 -> at t+201 busy=0, state_num=0, write_valid=0. No done. A fresh start afterwards completes a normal 16-pixel pass.
